// File: rtl/vr_sweep_sequencer.sv
// Wiper-code sweep sequencer for the dual digital-potentiometer programmer.
// Walks an R1 (outer) x R2 (inner) code grid, reprograms, settles, then handshakes each point.
module vr_sweep_sequencer #(
    parameter int PROG_CYCLES  = 32,
    parameter int DWELL_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [7:0]  r1_start_i,
    input  logic [7:0]  r1_end_i,
    input  logic [7:0]  r1_step_i,
    input  logic [7:0]  r2_start_i,
    input  logic [7:0]  r2_end_i,
    input  logic [7:0]  r2_step_i,
    input  logic        point_ack_i,
    output logic [7:0]  r1_o,
    output logic [7:0]  r2_o,
    output logic        chip_en_o,
    output logic        point_valid_o,
    output logic [15:0] point_idx_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_DISABLE, S_PROGRAM, S_SETTLE, S_VALID, S_DONE
    } state_t;

    localparam logic [15:0] LP_PROG_LAST  = 16'(PROG_CYCLES - 1);
    localparam logic [15:0] LP_DWELL_LAST = 16'(DWELL_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [7:0]  r_r1s, r_r1e, r_r1st, r_r2s, r_r2e, r_r2st;
    logic [7:0]  w_r1s_nxt, w_r1e_nxt, w_r1st_nxt, w_r2s_nxt, w_r2e_nxt, w_r2st_nxt;
    logic [7:0]  r_r1, r_r2, w_r1_nxt, w_r2_nxt;
    logic        r_chip_en, w_chip_en_nxt;
    logic        r_valid, w_valid_nxt;
    logic [15:0] r_idx, w_idx_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic [8:0]  w_sum1, w_sum2;
    logic        w_fin1, w_fin2;

    // 9-bit sum so a carry out of the code range ends the axis; step 0 behaves as 1
    function automatic logic [8:0] f_step_sum(input logic [7:0] code, input logic [7:0] step);
        logic [7:0] eff;
        eff = (step == 8'd0) ? 8'd1 : step;
        return {1'b0, code} + {1'b0, eff};
    endfunction

    assign w_sum1 = f_step_sum(r_r1, r_r1st);
    assign w_sum2 = f_step_sum(r_r2, r_r2st);
    assign w_fin1 = w_sum1[8] || (w_sum1 > {1'b0, r_r1e});
    assign w_fin2 = w_sum2[8] || (w_sum2 > {1'b0, r_r2e});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_r1s     <= '0;
            r_r1e     <= '0;
            r_r1st    <= '0;
            r_r2s     <= '0;
            r_r2e     <= '0;
            r_r2st    <= '0;
            r_r1      <= '0;
            r_r2      <= '0;
            r_chip_en <= 1'b1;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_r1s     <= w_r1s_nxt;
            r_r1e     <= w_r1e_nxt;
            r_r1st    <= w_r1st_nxt;
            r_r2s     <= w_r2s_nxt;
            r_r2e     <= w_r2e_nxt;
            r_r2st    <= w_r2st_nxt;
            r_r1      <= w_r1_nxt;
            r_r2      <= w_r2_nxt;
            r_chip_en <= w_chip_en_nxt;
            r_valid   <= w_valid_nxt;
            r_idx     <= w_idx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_r1s_nxt     = r_r1s;
        w_r1e_nxt     = r_r1e;
        w_r1st_nxt    = r_r1st;
        w_r2s_nxt     = r_r2s;
        w_r2e_nxt     = r_r2e;
        w_r2st_nxt    = r_r2st;
        w_r1_nxt      = r_r1;
        w_r2_nxt      = r_r2;
        w_chip_en_nxt = r_chip_en;
        w_valid_nxt   = r_valid;
        w_idx_nxt     = r_idx;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_chip_en_nxt = 1'b1;
                w_busy_nxt    = 1'b0;
                if (start_i && !stop_i) begin
                    w_r1s_nxt     = r1_start_i;
                    w_r1e_nxt     = r1_end_i;
                    w_r1st_nxt    = r1_step_i;
                    w_r2s_nxt     = r2_start_i;
                    w_r2e_nxt     = r2_end_i;
                    w_r2st_nxt    = r2_step_i;
                    w_r1_nxt      = r1_start_i;
                    w_r2_nxt      = r2_start_i;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_chip_en_nxt = 1'b0;
                    w_state_nxt   = S_DISABLE;
                end
            end
            S_DISABLE: begin
                if (r_cnt == 16'd1) begin
                    w_cnt_nxt     = '0;
                    w_chip_en_nxt = 1'b1;
                    w_state_nxt   = S_PROGRAM;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_PROGRAM: begin
                if (r_cnt == LP_PROG_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == LP_DWELL_LAST) begin
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_VALID;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_VALID: begin
                if (point_ack_i) begin
                    w_valid_nxt = 1'b0;
                    w_idx_nxt   = r_idx + 16'd1;
                    if (!w_fin2) begin
                        w_r2_nxt      = w_sum2[7:0];
                        w_chip_en_nxt = 1'b0;
                        w_state_nxt   = S_DISABLE;
                    end else if (!w_fin1) begin
                        w_r2_nxt      = r_r2s;
                        w_r1_nxt      = w_sum1[7:0];
                        w_chip_en_nxt = 1'b0;
                        w_state_nxt   = S_DISABLE;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort wins over everything else; codes and index freeze where they are
        if (stop_i && (r_state != S_IDLE) && (r_state != S_DONE)) begin
            w_state_nxt   = S_DONE;
            w_cnt_nxt     = '0;
            w_r1_nxt      = r_r1;
            w_r2_nxt      = r_r2;
            w_idx_nxt     = r_idx;
            w_valid_nxt   = 1'b0;
            w_chip_en_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
        end
    end

    assign r1_o          = r_r1;
    assign r2_o          = r_r2;
    assign chip_en_o     = r_chip_en;
    assign point_valid_o = r_valid;
    assign point_idx_o   = r_idx;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

endmodule

// File: tb/tb_vr_sweep_sequencer.sv
// Randomised self-checking bench for vr_sweep_sequencer against a grid/timeline model.
`timescale 1ns/1ps
module tb_vr_sweep_sequencer;

    localparam int PROG  = 24;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, ack;
    logic [7:0]  r1_start, r1_end, r1_step, r2_start, r2_end, r2_step;
    logic [7:0]  r1, r2;
    logic        chip_en, valid, busy, done;
    logic [15:0] idx;

    int n_checks = 0;
    int n_fail   = 0;

    vr_sweep_sequencer #(.PROG_CYCLES(PROG), .DWELL_CYCLES(DWELL)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .r1_start_i(r1_start), .r1_end_i(r1_end), .r1_step_i(r1_step),
        .r2_start_i(r2_start), .r2_end_i(r2_end), .r2_step_i(r2_step),
        .point_ack_i(ack), .r1_o(r1), .r2_o(r2), .chip_en_o(chip_en),
        .point_valid_o(valid), .point_idx_o(idx), .busy_o(busy), .done_o(done)
    );

    always #50 clk = ~clk;

    initial begin
        #6_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Grid is N1 x N2 points, value k on an axis = start + k*step (step 0 -> 1)
    function automatic int axis_n(input int s, input int e, input int st);
        int eff = (st == 0) ? 1 : st;
        return (s > e) ? 1 : ((e - s) / eff + 1);
    endfunction

    task automatic run_sweep(input int a1s, input int a1e, input int a1st,
                             input int a2s, input int a2e, input int a2st,
                             input int fixed_wait, input int abort_pt, input bit poke);
        int n1, n2, np, w, e1, e2;
        int p1[$], p2[$];
        e1 = (a1st == 0) ? 1 : a1st;
        e2 = (a2st == 0) ? 1 : a2st;
        n1 = axis_n(a1s, a1e, a1st);
        n2 = axis_n(a2s, a2e, a2st);
        for (int k1 = 0; k1 < n1; k1++)
            for (int k2 = 0; k2 < n2; k2++) begin
                p1.push_back(a1s + k1 * e1);
                p2.push_back(a2s + k2 * e2);
            end
        np = n1 * n2;

        @(negedge clk);
        r1_start = 8'(a1s); r1_end = 8'(a1e); r1_step = 8'(a1st);
        r2_start = 8'(a2s); r2_end = 8'(a2e); r2_step = 8'(a2st);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r1_start = 8'($urandom); r1_end = 8'($urandom); r1_step = 8'($urandom);
        r2_start = 8'($urandom); r2_end = 8'($urandom); r2_step = 8'($urandom);

        for (int i = 0; i < np; i++) begin
            check("dis_ce0", 32'(chip_en), 32'd0);
            check("dis_r1", 32'(r1), 32'(p1[i]));
            check("dis_r2", 32'(r2), 32'(p2[i]));
            check("dis_idx", 32'(idx), 32'(i));
            check("dis_busy", 32'(busy), 32'd1);
            check("dis_vld", 32'(valid), 32'd0);
            check("dis_done", 32'(done), 32'd0);
            @(negedge clk);
            check("dis_ce1", 32'(chip_en), 32'd0);
            for (int c = 0; c < PROG + DWELL; c++) begin
                @(negedge clk);
                check("wait_ce", 32'(chip_en), 32'd1);
                check("wait_vld", 32'(valid), 32'd0);
                check("wait_busy", 32'(busy), 32'd1);
                start = poke && (c == 2);
                ack   = poke && (c == 4);
                if (i == abort_pt && c == PROG + 1) begin
                    start = 1'b0;
                    ack   = 1'b0;
                    stop  = 1'b1;
                    @(negedge clk);
                    stop = 1'b0;
                    check("abort_done", 32'(done), 32'd1);
                    check("abort_busy", 32'(busy), 32'd0);
                    check("abort_vld", 32'(valid), 32'd0);
                    check("abort_ce", 32'(chip_en), 32'd1);
                    check("abort_r1", 32'(r1), 32'(p1[i]));
                    check("abort_r2", 32'(r2), 32'(p2[i]));
                    check("abort_idx", 32'(idx), 32'(i));
                    @(negedge clk);
                    check("abort_done_end", 32'(done), 32'd0);
                    check("abort_vld_end", 32'(valid), 32'd0);
                    return;
                end
            end
            start = 1'b0;
            ack   = 1'b0;
            @(negedge clk);
            check("vld_rise", 32'(valid), 32'd1);
            check("vld_r1", 32'(r1), 32'(p1[i]));
            check("vld_r2", 32'(r2), 32'(p2[i]));
            check("vld_idx", 32'(idx), 32'(i));
            w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(3));
            for (int c = 0; c < w; c++) begin
                start = poke && (c % 7 == 3);
                @(negedge clk);
                check("vld_hold", 32'(valid), 32'd1);
                check("hold_r1", 32'(r1), 32'(p1[i]));
                check("hold_r2", 32'(r2), 32'(p2[i]));
                check("hold_done", 32'(done), 32'd0);
            end
            start = 1'b0;
            ack   = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            if (i == np - 1) begin
                check("end_done", 32'(done), 32'd1);
                check("end_busy", 32'(busy), 32'd0);
                check("end_vld", 32'(valid), 32'd0);
                check("end_ce", 32'(chip_en), 32'd1);
                check("end_r1", 32'(r1), 32'(p1[i]));
                check("end_r2", 32'(r2), 32'(p2[i]));
                check("end_idx", 32'(idx), 32'(np));
                @(negedge clk);
                check("idle_done", 32'(done), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_ce", 32'(chip_en), 32'd1);
            end
        end
    endtask

    task automatic gen_axis(output int s, output int e, output int st);
        s = int'($urandom_range(255));
        if ($urandom_range(3) == 0) begin
            e  = int'($urandom_range(255));
            st = int'($urandom_range(255, 40));
        end else begin
            e  = s + int'($urandom_range(6));
            if (e > 255) e = 255;
            st = int'($urandom_range(3));
        end
    endtask

    initial begin
        int s1, e1, st1, s2, e2, st2;
        rst = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0;
        r1_start = '0; r1_end = '0; r1_step = '0;
        r2_start = '0; r2_end = '0; r2_step = '0;
        repeat (2) @(negedge clk);
        check("rst_r1", 32'(r1), 32'd0);
        check("rst_r2", 32'(r2), 32'd0);
        check("rst_ce", 32'(chip_en), 32'd1);
        check("rst_vld", 32'(valid), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_sweep(10, 20, 10, 5, 6, 1, 1, -1, 1'b0);
        run_sweep(7, 3, 1, 250, 255, 10, 0, -1, 1'b0);
        run_sweep(9, 9, 1, 0, 3, 0, -1, -1, 1'b0);
        run_sweep(10, 20, 10, 5, 6, 1, 0, 1, 1'b0);

        // start together with stop is refused in IDLE
        @(negedge clk);
        r1_start = 8'd33; r2_start = 8'd44;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        check("startstop_ce", 32'(chip_en), 32'd1);
        check("startstop_r1", 32'(r1), 32'd10);

        // asynchronous reset in the middle of PROGRAM
        @(negedge clk);
        r1_start = 8'd10; r1_end = 8'd20; r1_step = 8'd10;
        r2_start = 8'd5;  r2_end = 8'd6;  r2_step = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #10 rst = 1'b1;
        #1;
        check("arst_r1", 32'(r1), 32'd0);
        check("arst_r2", 32'(r2), 32'd0);
        check("arst_ce", 32'(chip_en), 32'd1);
        check("arst_vld", 32'(valid), 32'd0);
        check("arst_idx", 32'(idx), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        #5 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        run_sweep(10, 20, 10, 5, 6, 1, -1, -1, 1'b0);

        run_sweep(100, 101, 1, 200, 201, 0, 50, -1, 1'b1);

        for (int t = 0; t < 6; t++) begin
            gen_axis(s1, e1, st1);
            gen_axis(s2, e2, st2);
            run_sweep(s1, e1, st1, s2, e2, st2, -1, ($urandom_range(3) == 0) ? 0 : -1, t[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vr_sweep_sequencer.md
# vr_sweep_sequencer

Generates the sequence of wiper codes for the dual digital-potentiometer programmer in the signal conditioning tester: it walks a two-dimensional grid of R1/R2 codes, presents each pair on `r1_o`/`r2_o`, and pulses `chip_en_o` low to make the downstream programmer re-shift both words. After programming and a settling dwell it raises `point_valid_o` and holds until the measurement logic acknowledges. It sits directly upstream of the potentiometer programmer and downstream of the test-control registers.

## Interface
- `PROG_CYCLES`, 32, cycles `chip_en_o` stays high after re-enable before settling starts; must cover the programmer's full two-word shift of at least 23 cycles; range 1..65535
- `DWELL_CYCLES`, 1000, analog settling cycles before a point is declared valid; range 1..65535

- `clk_i`  in  1  system clock, 10 MHz, all logic on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  begin sweep, honoured only in IDLE
- `stop_i`  in  1  abort sweep from any non-IDLE state
- `r1_start_i`, `r1_end_i`, `r1_step_i`  in  8 each  outer-loop code range and step
- `r2_start_i`, `r2_end_i`, `r2_step_i`  in  8 each  inner-loop code range and step
- `point_ack_i`  in  1  measurement consumed, sampled only while `point_valid_o`=1
- `r1_o`, `r2_o`  out  8 each  current wiper codes, to programmer
- `chip_en_o`  out  1  programmer enable; low forces reprogram
- `point_valid_o`  out  1  current point programmed and settled
- `point_idx_o`  out  16  index of the current point, starting at 0
- `busy_o`  out  1  sweep in progress
- `done_o`  out  1  one-cycle pulse on completion or abort

## Operation
- Reset values: `r1_o`=0, `r2_o`=0, `chip_en_o`=1, `point_valid_o`=0, `point_idx_o`=0, `busy_o`=0, `done_o`=0. The state machine resets to IDLE and the counters to 0.
- All outputs are registered.
- The six range inputs are captured into shadow registers on an accepted start. Input changes during a sweep are ignored.
- A step of 0 is treated as 1.
- States:
  - IDLE: `chip_en_o`=1 and the codes hold their last values.
    - `start_i`=1 and `stop_i`=0: load `r1_o`=r1_start, `r2_o`=r2_start, clear `point_idx_o`, go to DISABLE.
    - `start_i` and `stop_i` both high: stay in IDLE.
  - DISABLE: 2 cycles with `chip_en_o`=0. Two cycles guarantee the programmer's falling-edge sampler sees the low. Then go to PROGRAM.
  - PROGRAM: `chip_en_o`=1 for PROG_CYCLES cycles, then go to SETTLE.
  - SETTLE: DWELL_CYCLES cycles, then go to VALID.
  - VALID: `point_valid_o`=1 until `point_ack_i`=1. On the ack edge:
    - `point_valid_o`←0 and `point_idx_o`+1 (wraps at 16 bits).
    - Codes advance as described below.
    - Go to DISABLE, or go to DONE if that was the last point.
  - DONE: 1 cycle with `done_o`=1 and `busy_o`←0, then go to IDLE.
- `busy_o`=1 in every state except IDLE and DONE.
- Code advance uses 9-bit arithmetic:
  - Inner loop: sum = r2 + step2. If sum[8]=1 or sum > r2_end, the inner loop is finished. Otherwise `r2_o`←sum[7:0].
  - Inner loop finished: `r2_o`←r2_start and r1 advances by the same rule. If r1 is also finished, the sweep is complete. On completion the codes hold the last point's values.
  - If start > end on either axis, that axis yields exactly one point, at start.
- Abort:
  - `stop_i`=1 in any non-IDLE state → DONE on the next edge, `point_valid_o`←0, `chip_en_o`←1.
  - The codes hold their current values and `point_idx_o` does not increment.
- Asynchronous reset mid-sweep returns all registers to their reset values immediately, with no `done_o` pulse.

## Timing
- `start_i` sampled at edge 0:
  - `busy_o`, loaded codes and `chip_en_o`=0 appear after edge 0.
  - `chip_en_o` returns to 1 after edge 2.
  - `point_valid_o` rises after edge 2+PROG_CYCLES+DWELL_CYCLES.
- `point_ack_i` sampled at edge a: the new codes and `chip_en_o`=0 appear after edge a.
- Per-point period = 2+PROG_CYCLES+DWELL_CYCLES cycles plus the ack wait (ack in the first valid cycle adds 1).
- `point_ack_i` outside VALID is ignored. `start_i` while busy is ignored.
- Total point count = N1×N2, where N = floor((end−start)/step)+1, or 1 if start > end.

## Test plan
- r1 10→20 step 10, r2 5→6 step 1, PROG=24, DWELL=4, ack one cycle after each valid → points (10,5),(10,6),(20,5),(20,6); idx 0..3; first valid after edge 30; `done_o` pulse after the 4th ack; `chip_en_o` low exactly 2 cycles before each point.
- r2 250→255 step 10 → single inner point 250 (carry case). r1 7→3 → single point 7. Expect exactly 1 point total.
- r2 step=0, r2 0→3, r1 fixed at 9→9 → 4 points, r2 = 0,1,2,3.
- `stop_i` pulsed in the 2nd cycle of SETTLE of point 1 → `done_o` on the next cycle, `point_valid_o` never rises for point 1, codes held, `busy_o`=0, `chip_en_o`=1.
- `rst_i` asserted asynchronously mid-PROGRAM → all outputs at reset values before the next clock edge, no `done_o`. A subsequent start runs normally from idx 0.
- `point_ack_i` held low for 50 cycles in VALID → `point_valid_o` stays 1, codes stable. `start_i` pulsed during the sweep has no effect.
